// File: rtl/mem_stage_ctrl_if.sv
// Purpose : data-memory bus bundle between the M-stage controller and memory.
// Latency : n/a (wires only); the master registers req/we/addr/wdata.
// Backpr. : memory holds mem_ready low to extend an access; master keeps req stable.
// Ports   : mem_req/mem_we/mem_addr/mem_wdata (master->slave), mem_ready/mem_rdata (slave->master).
interface mem_stage_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Purpose : M-stage controller; turns load/store into a req/ready bus access and stalls the pipe.
// Latency : request 1 cycle after the access is seen, result in DONE; 2 stall cycles minimum.
// Backpr. : stallM held while the bus withholds mem_ready; aborts after TIMEOUT_CYCLES (sticky bus_err).
// Ports   : clk/reset; aluoutM, writedataM, memwriteM, memreadM in; readdataM, stallM, misalignM,
//           bus_err out; bus = master side of mem_stage_ctrl_if.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             aluoutM,
    input  logic [31:0]             writedataM,
    input  logic                    memwriteM,
    input  logic                    memreadM,
    output logic [31:0]             readdataM,
    output logic                    stallM,
    output logic                    misalignM,
    output logic                    bus_err,
    mem_stage_ctrl_if.master        bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_bus_err;

    logic             w_memop;
    logic             w_access;

    assign w_memop   = memreadM | memwriteM;
    assign misalignM = w_memop & (aluoutM[1:0] != 2'b00);
    assign w_access  = w_memop & ~misalignM;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_bus_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        r_state <= ST_BUSY;
                        r_req   <= 1'b1;
                        // A read+write combination is issued as a write.
                        r_we    <= memwriteM;
                        r_addr  <= {aluoutM[31:2], 2'b00};
                        r_wdata <= writedataM;
                        r_cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    // Completion wins over timeout when both land in the same cycle.
                    if (bus.mem_ready) begin
                        r_req   <= 1'b0;
                        r_state <= ST_DONE;
                        if (!r_we) begin
                            r_rdata <= bus.mem_rdata;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_req     <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_rdata   <= '0;
                        r_state   <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    // Stall starts combinationally in IDLE so the instruction is frozen before the
    // request is even registered; DONE releases it so the instruction advances.
    assign stallM    = ~reset & (((r_state == ST_IDLE) & w_access) | (r_state == ST_BUSY));
    assign readdataM = (~reset & (r_state == ST_DONE) & memreadM) ? r_rdata : 32'd0;
    assign bus_err   = r_bus_err;

    assign bus.mem_req   = r_req;
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Purpose : self-checking bench for mem_stage_ctrl with a scoreboard of expected load results.
// Latency : memory responder returns mem_ready after a per-access number of wait cycles.
// Backpr. : responder can withhold mem_ready indefinitely to force the timeout path.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        memwriteM;
    logic        memreadM;
    logic [31:0] readdataM;
    logic        stallM;
    logic        misalignM;
    logic        bus_err;

    int n_tests;
    int n_fail;

    logic [31:0] exp_q[$];

    mem_stage_ctrl_if bus_if ();

    mem_stage_ctrl #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .aluoutM   (aluoutM),
        .writedataM(writedataM),
        .memwriteM (memwriteM),
        .memreadM  (memreadM),
        .readdataM (readdataM),
        .stallM    (stallM),
        .misalignM (misalignM),
        .bus_err   (bus_err),
        .bus       (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        aluoutM          = 32'd0;
        writedataM       = 32'd0;
        memreadM         = 1'b0;
        memwriteM        = 1'b0;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_rdata = 32'd0;
    endtask

    // Drive one M-stage op, act as memory, and check stall/request counts and result.
    // waits: cycles of mem_ready=0 before completion (negative = never respond).
    task automatic run_access(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic rd, input logic wr, input int waits,
                              input logic [31:0] rdata, input int exp_stall, input int exp_req,
                              input logic [31:0] exp_rd);
        int          stall_cnt;
        int          req_cnt;
        bit          done;
        logic [31:0] exp_val;
        logic        exp_mis;
        @(posedge clk);
        #1;
        aluoutM    = addr;
        writedataM = wdata;
        memreadM   = rd;
        memwriteM  = wr;
        exp_q.push_back(exp_rd);
        exp_mis   = (rd | wr) & (addr[1:0] != 2'b00);
        stall_cnt = 0;
        req_cnt   = 0;
        done      = 1'b0;
        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0) chk({tag, " misalign"}, 32'(misalignM), 32'(exp_mis));
            if (bus_if.mem_req) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    chk({tag, " addr"},  bus_if.mem_addr,  {addr[31:2], 2'b00});
                    chk({tag, " we"},    32'(bus_if.mem_we), 32'(wr));
                    if (wr) chk({tag, " wdata"}, bus_if.mem_wdata, wdata);
                end
                if (waits >= 0 && req_cnt == waits + 1) begin
                    bus_if.mem_ready = 1'b1;
                    bus_if.mem_rdata = rdata;
                end else begin
                    bus_if.mem_ready = 1'b0;
                    bus_if.mem_rdata = 32'hDEAD_BEEF;
                end
            end else if (waits >= 0) begin
                bus_if.mem_ready = 1'b0;
            end
            if (stallM) begin
                stall_cnt++;
            end else begin
                done = 1'b1;
                if (exp_q.size() == 0) begin
                    chk({tag, " scoreboard empty"}, 32'd1, 32'd0);
                end else begin
                    exp_val = exp_q.pop_front();
                    chk({tag, " readdata"}, readdataM, exp_val);
                end
                chk({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_stall));
                chk({tag, " req cycles"},   32'(req_cnt),   32'(exp_req));
            end
        end
        if (!done) chk({tag, " completion timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset stall",    32'(stallM),           32'd0);
        chk("reset readdata", readdataM,             32'd0);
        chk("reset req",      32'(bus_if.mem_req),   32'd0);
        chk("reset addr",     bus_if.mem_addr,       32'd0);
        chk("reset bus_err",  32'(bus_err),          32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Load, zero wait states.
        run_access("t1 load",   32'h100, 32'h0, 1'b1, 1'b0, 0, 32'hCAFE_F00D, 2, 1, 32'hCAFE_F00D);
        // Store with 3 wait cycles.
        run_access("t2 store",  32'h204, 32'h1234_5678, 1'b0, 1'b1, 3, 32'h5555_AAAA, 5, 4, 32'h0);
        // Back-to-back load after 2 waits.
        run_access("t2b load",  32'h208, 32'h0, 1'b1, 1'b0, 2, 32'h0BAD_F00D, 4, 3, 32'h0BAD_F00D);
        // Misaligned load.
        run_access("t3 mis",    32'h102, 32'h0, 1'b1, 1'b0, 0, 32'h1111_1111, 0, 0, 32'h0);
        // Read+write together is a store; readdataM still follows memreadM and shows last load data.
        run_access("rw both",   32'h30C, 32'hA5A5_5A5A, 1'b1, 1'b1, 1, 32'h7777_7777, 3, 2, 32'h0BAD_F00D);

        // Non-memory op with stray mem_ready.
        @(posedge clk);
        #1;
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h9999_9999;
        run_access("t6 nop",    32'h400, 32'h0, 1'b0, 1'b0, -1, 32'h0, 0, 0, 32'h0);

        chk("bus_err before timeout", 32'(bus_err), 32'd0);
        // Timeout: never respond.
        run_access("t4 tmo",    32'h500, 32'h0, 1'b1, 1'b0, -1, 32'h0, 5, 4, 32'h0);
        @(negedge clk);
        chk("t4 bus_err set", 32'(bus_err), 32'd1);
        run_access("t4 after",  32'h504, 32'h0, 1'b1, 1'b0, 0, 32'h1357_9BDF, 2, 1, 32'h1357_9BDF);
        chk("t4 bus_err sticky", 32'(bus_err), 32'd1);

        // Reset in the second BUSY cycle.
        @(posedge clk);
        #1;
        aluoutM  = 32'h600;
        memreadM = 1'b1;
        @(posedge clk);                 // enters BUSY
        @(posedge clk);                 // second BUSY cycle begins
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t5 req in busy", 32'(bus_if.mem_req), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'hFFFF_0000;
        @(negedge clk);
        chk("t5 req after reset",   32'(bus_if.mem_req), 32'd0);
        chk("t5 stall after reset", 32'(stallM),         32'd0);
        chk("t5 bus_err cleared",   32'(bus_err),        32'd0);
        @(posedge clk);
        #1;
        bus_if.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5 req stays low", 32'(bus_if.mem_req), 32'd0);
        chk("t5 readdata",      readdataM,           32'd0);

        run_access("t5 after",  32'h700, 32'h0, 1'b1, 1'b0, 1, 32'h2468_ACE0, 3, 2, 32'h2468_ACE0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
